// File: rtl/ccff_config_loader.sv
// Configuration-chain loader: takes host words over valid/ready, shifts them MSB-first into
// the ccff chain and optionally checks that the tail reads zero while the chain is loaded.
module ccff_config_loader #(
    parameter int CHAIN_LEN = 62,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              chk_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BL_W          = $clog2(WORD_W + 1);
    localparam int NUM_WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS     = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
    localparam logic [CNT_W-1:0] NUM_WORDS_C  = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD_C  = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_BIT_C   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BL_W-1:0]  FULL_BITS_C  = BL_W'(WORD_W);
    localparam logic [BL_W-1:0]  LAST_BITS_C  = BL_W'(LAST_BITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] sreg_reg;
    logic [BL_W-1:0]   bits_left_reg;
    logic [CNT_W-1:0]  bit_total_reg;
    logic [CNT_W-1:0]  words_acc_reg;
    logic              chk_reg;
    logic              error_reg;

    logic shifting;
    logic accept;
    logic last_shift;
    logic start_load;

    assign shifting   = (state_reg == ST_LOAD) && (bits_left_reg != '0);
    // A new word may land on the same edge the buffer's final bit leaves, keeping shifts gapless.
    assign cfg_ready  = (state_reg == ST_LOAD) && (words_acc_reg < NUM_WORDS_C) &&
                        ((bits_left_reg == '0) || ((bits_left_reg == BL_W'(1)) && shifting));
    assign accept     = cfg_valid && cfg_ready;
    assign last_shift = shifting && (bit_total_reg == LAST_BIT_C);
    assign start_load = start && (state_reg != ST_LOAD);

    assign ccff_head     = sreg_reg[WORD_W-1];
    assign ccff_shift_en = shifting;
    assign busy          = (state_reg == ST_LOAD);
    assign done          = (state_reg == ST_DONE);
    assign error         = error_reg;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (start)      state_next = ST_LOAD;
                ST_LOAD: if (last_shift) state_next = ST_DONE;
                ST_DONE: if (start)      state_next = ST_LOAD;
                default:                 state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sreg_reg      <= '0;
            bits_left_reg <= '0;
            bit_total_reg <= '0;
            words_acc_reg <= '0;
            chk_reg       <= 1'b0;
            error_reg     <= 1'b0;
        end else if (abort) begin
            sreg_reg      <= '0;
            bits_left_reg <= '0;
            bit_total_reg <= '0;
            words_acc_reg <= '0;
        end else if (start_load) begin
            sreg_reg      <= '0;
            bits_left_reg <= '0;
            bit_total_reg <= '0;
            words_acc_reg <= '0;
            chk_reg       <= chk_en;
            error_reg     <= 1'b0;
        end else if (state_reg == ST_LOAD) begin
            if (shifting) begin
                sreg_reg      <= sreg_reg << 1;
                bits_left_reg <= bits_left_reg - BL_W'(1);
                bit_total_reg <= bit_total_reg + CNT_W'(1);
                if (chk_reg && ccff_tail) begin
                    error_reg <= 1'b1;
                end
                // Drop the unused low bits of the final word so they never reach the head.
                if (last_shift) begin
                    sreg_reg      <= '0;
                    bits_left_reg <= '0;
                end
            end
            if (accept) begin
                sreg_reg      <= cfg_data;
                bits_left_reg <= (words_acc_reg == LAST_WORD_C) ? LAST_BITS_C : FULL_BITS_C;
                words_acc_reg <= words_acc_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ccff_config_loader.sv
// Directed bench for ccff_config_loader with a 62-bit behavioural chain on head/tail.
module tb_ccff_config_loader;

    localparam int CHAIN_LEN = 62;
    localparam int WORD_W    = 8;

    logic              prog_clk = 1'b0;
    logic              pReset   = 1'b1;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic              chk_en   = 1'b0;
    logic [WORD_W-1:0] cfg_data = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              ccff_shift_en;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] words [8];
    logic              mon_bits [128];
    int                mon_cnt;
    int                low_cycles;
    int                done_delay;
    logic              err_after1;
    logic              timed_out;

    logic [CHAIN_LEN-1:0] chain;

    always #5 prog_clk = ~prog_clk;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) chain <= '0;
        else if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    ccff_config_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(16)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort), .chk_en(chk_en),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
        .busy(busy), .done(done), .error(error)
    );

    task automatic do_start(input logic chk);
        @(posedge prog_clk); #1;
        start = 1'b1; chk_en = chk;
        @(posedge prog_clk); #1;
        start = 1'b0; chk_en = 1'b0;
    endtask

    // Feeds words[] and records every shifted head bit; gap_after: word index followed by a
    // 12-cycle valid drop; stop_after: return once that many shifts have happened.
    task automatic run_load(input int gap_after, input int stop_after, input int start_at);
        int   idx, gap, cyc, first, last;
        logic fire;
        idx = 0; gap = 0; cyc = 0; first = -1; last = -1;
        mon_cnt = 0; err_after1 = 1'bx; timed_out = 1'b0; done_delay = -1;
        cfg_valid = 1'b1; cfg_data = words[0];
        forever begin
            @(negedge prog_clk);
            if (first >= 0 && cyc == first + 1) err_after1 = error;
            if (done) begin
                done_delay = cyc - last;
                break;
            end
            if (stop_after > 0 && mon_cnt == stop_after) break;
            if (cyc > 500) begin
                timed_out = 1'b1;
                break;
            end
            if (ccff_shift_en) begin
                mon_bits[mon_cnt] = ccff_head;
                mon_cnt++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            fire = cfg_valid && cfg_ready;
            @(posedge prog_clk); #1;
            cyc++;
            start = (start_at > 0 && cyc == start_at);
            if (fire) begin
                idx++;
                if (idx - 1 == gap_after) gap = 12;
            end
            if (gap > 0) begin
                cfg_valid = 1'b0;
                gap--;
            end else begin
                cfg_valid = (idx < 8);
            end
            cfg_data = words[(idx < 8) ? idx : 0];
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        low_cycles = (first < 0) ? 0 : (last - first + 1 - mon_cnt);
    endtask

    task automatic check_bits(input string name, input int n);
        int   bad_idx;
        logic exp_bit;
        bad_idx = -1;
        for (int i = 0; i < n; i++) begin
            exp_bit = words[i / 8][7 - (i % 8)];
            if (mon_bits[i] !== exp_bit && bad_idx < 0) bad_idx = i;
        end
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s: head bit %0d actual %b required %b", name, bad_idx,
                     mon_bits[bad_idx], words[bad_idx / 8][7 - (bad_idx % 8)]);
        end else begin
            $display("%s: %0d head bits in order", name, n);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, error, cfg_ready, ccff_head, ccff_shift_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: outputs actual %b required 000000",
                     {busy, done, error, cfg_ready, ccff_head, ccff_shift_en});
        end
        repeat (3) @(posedge prog_clk);
        #1 pReset = 1'b0;
        cfg_valid = 1'b1; cfg_data = 8'hA5;
        @(posedge prog_clk); #1;
        checks++;
        if ({busy, done, error, cfg_ready, ccff_shift_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle: busy/done/error/ready/shift actual %b required 00000",
                     {busy, done, error, cfg_ready, ccff_shift_en});
        end else $display("reset: idle outputs low, word refused in IDLE");
        cfg_valid = 1'b0;
    endtask

    task automatic test_basic;
        for (int i = 0; i < 8; i++) words[i] = 8'hA5;
        do_start(1'b1);
        run_load(-1, 0, 0);
        checks++;
        if (mon_cnt != 62 || timed_out) begin
            errors++;
            $display("FAIL basic_count: shifts actual %0d required 62 (timeout %b)", mon_cnt, timed_out);
        end
        checks++;
        if (low_cycles != 0) begin
            errors++;
            $display("FAIL basic_gapless: idle cycles actual %0d required 0", low_cycles);
        end
        check_bits("basic_bits", 62);
        checks++;
        if (done_delay != 1 || error !== 1'b0 || ccff_shift_en !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: delay %0d err %b shift %b ready %b required 1 0 0 0",
                     done_delay, error, ccff_shift_en, cfg_ready);
        end else $display("basic: 62 shifts, done after 1 cycle, error 0");
    endtask

    task automatic test_stall;
        do_start(1'b0);
        run_load(2, 0, 0);
        checks++;
        if (mon_cnt != 62 || low_cycles != 5) begin
            errors++;
            $display("FAIL stall_gap: shifts %0d idle %0d required 62 5", mon_cnt, low_cycles);
        end else $display("stall: 62 shifts with 5 idle cycles");
        check_bits("stall_bits", 62);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done %b error %b required 1 0", done, error);
        end
    endtask

    task automatic test_tail_check;
        do_start(1'b1);
        run_load(-1, 0, 0);
        checks++;
        if (err_after1 !== 1'b1) begin
            errors++;
            $display("FAIL tail_first: error after first shift actual %b required 1", err_after1);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b1 || mon_cnt != 62) begin
            errors++;
            $display("FAIL tail_sticky: done %b error %b shifts %0d required 1 1 62", done, error, mon_cnt);
        end else $display("tail_check: error raised and held through DONE");
    endtask

    task automatic test_last_word;
        for (int i = 0; i < 7; i++) words[i] = 8'h00;
        words[7] = 8'hFF;
        do_start(1'b0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL last_start: error %b busy %b required 0 1", error, busy);
        end
        run_load(-1, 0, 0);
        checks++;
        if (mon_cnt != 62 || timed_out) begin
            errors++;
            $display("FAIL last_count: shifts actual %0d required 62", mon_cnt);
        end
        check_bits("last_bits", 62);
        repeat (2) @(negedge prog_clk);
        checks++;
        if (ccff_head !== 1'b0 || ccff_shift_en !== 1'b0) begin
            errors++;
            $display("FAIL last_dropped: head %b shift %b in DONE required 0 0", ccff_head, ccff_shift_en);
        end else $display("last_word: 6 bits of 0xFF shifted, low bits dropped");
    endtask

    task automatic test_abort;
        for (int i = 0; i < 8; i++) words[i] = 8'hA5;
        do_start(1'b0);
        run_load(-1, 20, 0);
        abort = 1'b1;
        @(posedge prog_clk); #1;
        abort = 1'b0;
        checks++;
        if ({busy, ccff_shift_en, cfg_ready, done} !== 4'b0 || mon_cnt != 20) begin
            errors++;
            $display("FAIL abort_idle: busy/shift/ready/done %b shifts %0d required 0000 20",
                     {busy, ccff_shift_en, cfg_ready, done}, mon_cnt);
        end else $display("abort: back to IDLE after 20 shifts");
        cfg_valid = 1'b1;
        @(negedge prog_clk);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready: cfg_ready actual %b required 0", cfg_ready);
        end
        cfg_valid = 1'b0;
        words[0] = 8'h3C; words[5] = 8'h81;
        do_start(1'b0);
        run_load(-1, 0, 0);
        checks++;
        if (mon_cnt != 62 || done !== 1'b1) begin
            errors++;
            $display("FAIL abort_reload: shifts %0d done %b required 62 1", mon_cnt, done);
        end
        check_bits("abort_reload_bits", 62);
    endtask

    task automatic test_preset;
        words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h7E; words[3] = 8'h00;
        words[4] = 8'hFF; words[5] = 8'h5A; words[6] = 8'hC3; words[7] = 8'h96;
        do_start(1'b0);
        run_load(-1, 30, 0);
        pReset = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, cfg_ready, ccff_head, ccff_shift_en} !== 6'b0 || mon_cnt != 30) begin
            errors++;
            $display("FAIL preset_async: outputs %b shifts %0d required 000000 30",
                     {busy, done, error, cfg_ready, ccff_head, ccff_shift_en}, mon_cnt);
        end else $display("preset: outputs cleared asynchronously after 30 shifts");
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        do_start(1'b1);
        run_load(-1, 0, 10);
        checks++;
        if (mon_cnt != 62 || done_delay != 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL preset_reload: shifts %0d delay %0d error %b required 62 1 0",
                     mon_cnt, done_delay, error);
        end else $display("preset: reload ignored mid-load start, error 0 on cleared chain");
        check_bits("preset_bits", 62);
        do_start(1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_restart: busy %b done %b required 1 0", busy, done);
        end
        run_load(-1, 0, 0);
        checks++;
        if (mon_cnt != 62 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_restart_load: shifts %0d done %b required 62 1", mon_cnt, done);
        end else $display("restart from DONE: 62 shifts");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_tail_check;
        test_last_word;
        test_abort;
        test_preset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
